// File: rtl/mips_pc_unit.sv
// -----------------------------------------------------------------------------
// mips_pc_unit
//
// Program-counter datapath slice of a multi-cycle MIPS core. It holds the PC,
// the instruction register, the registered ALU result (ALUOut) and the
// registered zero flag. It selects the next PC from the control FSM's PCSource
// and applies the PCWrite / PCWriteCond strobes. Two sticky fault flags are
// kept:
//   * misalign -- a PC update was attempted with a target not word aligned.
//   * halted   -- set by misalign or by the control FSM's Error flag.
//                 While halted the PC is frozen. Only rst clears it.
//
// Optional feature (compile-time macro MIPS_PC_STATS_EN):
//   When defined, three saturating 16-bit statistics counters are built
//   (branch taken, branch not taken, jump). When undefined, the counter ports
//   remain but are tied to zero, and no counter logic exists.
//
// Parameters
//   RESET_PC          PC value loaded on reset.
//
// Ports
//   clk               system clock; all state updates on its rising edge
//   rst               synchronous, active-high reset; overrides every input
//   alu_result[31:0]  combinational ALU output for this cycle
//   alu_zero          ALU zero flag for this cycle
//   rs_value[31:0]    register rs, used as the jr target
//   mem_rdata[31:0]   memory read data (the instruction during fetch)
//   PCWrite           unconditional PC update strobe (dominant)
//   PCWriteCond       conditional (branch) PC update strobe
//   EQorNE            1 = beq (taken on zero), 0 = bne (taken on nonzero)
//   IRWrite           load the instruction register from mem_rdata
//   PCSource[1:0]     next-PC select: 00 alu_result, 01 alu_out,
//                     10 jump target, 11 rs_value
//   Error             control FSM error flag; halts the unit
//   pc[31:0]          current program counter
//   instr[31:0]       instruction register
//   alu_out[31:0]     ALU result registered every cycle
//   misalign, halted  sticky fault flags
//   branch_taken_cnt, branch_nt_cnt, jump_cnt [15:0]  statistics counters
//
// Strobe semantics: the strobes are plain level-sampled controls, not a
// valid/ready handshake. Each strobe takes effect at the rising edge that
// samples it high. Nothing ever back-pressures the control FSM.
// -----------------------------------------------------------------------------
module mips_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] rs_value,
  input  logic [31:0] mem_rdata,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        EQorNE,
  input  logic        IRWrite,
  input  logic [1:0]  PCSource,
  input  logic        Error,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] alu_out,
  output logic        misalign,
  output logic        halted,
  output logic [15:0] branch_taken_cnt,
  output logic [15:0] branch_nt_cnt,
  output logic [15:0] jump_cnt
);

  localparam logic [1:0] SRC_ALU    = 2'b00;
  localparam logic [1:0] SRC_ALUOUT = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_RS     = 2'b11;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] alu_out_q,  alu_out_d;
  logic        zero_q,     zero_d;
  logic        misalign_q, misalign_d;
  logic        halted_q,   halted_d;

  // ---------------------------------------------------------------------------
  // Next-PC selection and update enable
  // ---------------------------------------------------------------------------
  logic [31:0] next_pc;
  logic [31:0] jump_target;
  logic        branch_ok;
  logic        pc_en;
  logic        target_misaligned;

  // The jump target is built from the instruction register as it stands
  // before this edge. If IRWrite is also high this cycle, the new word lands
  // in instr_q at the same edge and does not affect this jump.
  assign jump_target = {pc_q[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    next_pc = alu_result;
    case (PCSource)
      SRC_ALU:    next_pc = alu_result;
      SRC_ALUOUT: next_pc = alu_out_q;
      SRC_JUMP:   next_pc = jump_target;
      SRC_RS:     next_pc = rs_value;
      default:    next_pc = alu_result;
    endcase
  end

  // zero_q is the flag from the compare cycle, one cycle before the
  // PCWriteCond cycle. beq (EQorNE=1) takes the branch on zero. bne
  // (EQorNE=0) takes it on nonzero.
  assign branch_ok = (zero_q == EQorNE);

  // PCWrite dominates: with PCWrite high the branch condition is irrelevant.
  assign pc_en = !halted_q && !Error && (PCWrite || (PCWriteCond && branch_ok));

  assign target_misaligned = (next_pc[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    alu_out_d  = alu_result;
    zero_d     = alu_zero;
    misalign_d = misalign_q;
    halted_d   = halted_q;

    // Fetching is independent of the halt state, so the instruction register
    // keeps tracking memory even after a fault. This helps post-mortem debug.
    if (IRWrite) begin
      instr_d = mem_rdata;
    end

    if (pc_en) begin
      if (target_misaligned) begin
        // The PC is not updated with a bad target. The unit stops instead.
        misalign_d = 1'b1;
        halted_d   = 1'b1;
      end else begin
        pc_d = next_pc;
      end
    end

    if (Error) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      alu_out_q  <= 32'h0000_0000;
      zero_q     <= 1'b0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      alu_out_q  <= alu_out_d;
      zero_q     <= zero_d;
      misalign_q <= misalign_d;
      halted_q   <= halted_d;
    end
  end

  assign pc       = pc_q;
  assign instr    = instr_q;
  assign alu_out  = alu_out_q;
  assign misalign = misalign_q;
  assign halted   = halted_q;

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
`ifdef MIPS_PC_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] nt_cnt_q,    nt_cnt_d;
  logic [15:0] jump_cnt_q,  jump_cnt_d;
  logic        inc_taken;
  logic        inc_nt;
  logic        inc_jump;

  // A branch cycle is PCWriteCond alone. If PCWrite is also high, the cycle
  // is an unconditional update and is not counted as a branch.
  assign inc_taken = PCWriteCond && !PCWrite && branch_ok && pc_en;
  assign inc_nt    = PCWriteCond && !PCWrite && !branch_ok && !halted_q;
  assign inc_jump  = PCWrite && PCSource[1] && pc_en;

  // Each counter saturates at all-ones and holds there until reset.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    nt_cnt_d    = nt_cnt_q;
    jump_cnt_d  = jump_cnt_q;
    if (inc_taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
    if (inc_nt && (nt_cnt_q != 16'hFFFF)) begin
      nt_cnt_d = nt_cnt_q + 16'd1;
    end
    if (inc_jump && (jump_cnt_q != 16'hFFFF)) begin
      jump_cnt_d = jump_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q <= 16'h0000;
      nt_cnt_q    <= 16'h0000;
      jump_cnt_q  <= 16'h0000;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      nt_cnt_q    <= nt_cnt_d;
      jump_cnt_q  <= jump_cnt_d;
    end
  end

  assign branch_taken_cnt = taken_cnt_q;
  assign branch_nt_cnt    = nt_cnt_q;
  assign jump_cnt         = jump_cnt_q;
`else
  assign branch_taken_cnt = 16'h0000;
  assign branch_nt_cnt    = 16'h0000;
  assign jump_cnt         = 16'h0000;
`endif

endmodule

// File: doc/mips_pc_unit.md
MIPS_PC_UNIT -- requirements
Module: mips_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 SHALL have port alu_result, input, 32, the combinational ALU output for the current cycle.
REQ-005 SHALL have port alu_zero, input, 1, the ALU zero flag for the current cycle.
REQ-006 SHALL have port rs_value, input, 32, the register-A (rs) value, used as the jr target.
REQ-007 SHALL have port mem_rdata, input, 32, the memory read data.
REQ-008 SHALL have ports PCWrite, PCWriteCond, EQorNE and IRWrite, each input, 1, the control strobes from the control FSM.
REQ-009 SHALL have port PCSource, input, 2, the next-PC select.
REQ-010 SHALL have port Error, input, 1, the control FSM error flag.
REQ-011 SHALL have port pc, output, 32, the current program counter.
REQ-012 SHALL have port instr, output, 32, the instruction register.
REQ-013 SHALL have port alu_out, output, 32, the registered ALU result.
REQ-014 SHALL have ports misalign and halted, each output, 1, the sticky fault flags.
REQ-015 SHALL have ports branch_taken_cnt, branch_nt_cnt and jump_cnt, each output, 16, the statistics counters (see Configuration).

Function
REQ-016 SHALL register alu_result into alu_out, and alu_zero into an internal zero_q, every cycle unconditionally.
REQ-017 SHALL compute next_pc combinationally from PCSource:
- 00: alu_result
- 01: alu_out
- 10: {pc[31:28], instr[25:0], 2'b00}
- 11: rs_value
REQ-018 SHALL define branch_ok = (zero_q == EQorNE), i.e. beq taken on zero, bne taken on nonzero; the registered flag comes from the preceding compare cycle.
REQ-019 SHALL define pc_en = !halted & !Error & (PCWrite | (PCWriteCond & branch_ok)).
REQ-020 SHALL treat PCWrite as dominant when PCWrite and PCWriteCond are both high: unconditional update.
REQ-021 SHALL load pc <= next_pc on pc_en when next_pc[1:0] == 2'b00, with one-cycle latency.
REQ-022 SHALL handle pc_en with next_pc[1:0] != 0 as follows: pc is held, and misalign and halted are set next cycle.
REQ-023 SHALL set halted next cycle when Error is sampled high; halted holds pc and blocks all further updates.
REQ-024 SHALL keep halted and misalign sticky until rst.
REQ-025 SHALL load instr <= mem_rdata on IRWrite, regardless of halted.
REQ-026 SHALL, when IRWrite and pc_en occur in the same cycle, have both registers sample pre-edge values; the jump target uses the old instr.
REQ-027 SHALL compute all PC arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 requires no special handling.

Reset
REQ-028 SHALL, on rst high at a clock edge, set pc=RESET_PC, instr=0, alu_out=0, zero_q=0, misalign=0, halted=0, all counters=0.
REQ-029 SHALL give rst priority over every other input in the same cycle, including mid-branch and while halted.

Configuration
REQ-030 SHALL, when macro MIPS_PC_STATS_EN is defined, increment saturating 16-bit counters once per qualifying cycle:
- branch_taken_cnt: PCWriteCond & !PCWrite & branch_ok & pc_en
- branch_nt_cnt: PCWriteCond & !PCWrite & !branch_ok & !halted
- jump_cnt: PCWrite & PCSource[1] & pc_en
REQ-031 SHALL hold each counter at 16'hFFFF once reached.
REQ-032 SHALL, when MIPS_PC_STATS_EN is undefined, keep the counter ports present, drive them constant 0 and instantiate no counter logic.

Verification
REQ-033 SHALL cover fetch: reset, then PCWrite=1, PCSource=00, alu_result=32'h4, IRWrite=1, mem_rdata=32'h2008_0005 -> next cycle pc=32'h4, instr=32'h2008_0005.
REQ-034 SHALL cover beq taken: alu_zero=1 in cycle N; in N+1 PCWriteCond=1, EQorNE=1, alu_result=32'h40 -> pc=32'h40 (branch_taken_cnt=1 with stats).
REQ-035 SHALL cover bne not taken: alu_zero=1, then PCWriteCond=1, EQorNE=0 -> pc unchanged (branch_nt_cnt=1 with stats).
REQ-036 SHALL cover jump: pc=32'h1000_0008, instr=32'h0800_0010, PCWrite=1, PCSource=10 -> pc=32'h1000_0040; PCSource=11 with rs_value=32'h88 -> pc=32'h88.
REQ-037 SHALL cover misalign: PCSource=11, rs_value=32'h0000_0102, PCWrite=1 -> pc held, misalign=1, halted=1; later PCWrite ignored until rst.
REQ-038 SHALL cover Error and saturation: Error=1 -> halted=1 and pc frozen; with stats, 65536 taken branches -> branch_taken_cnt=16'hFFFF.
